// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank. Register 0 is a read-only ID word.
// Registers 1..NUM_REGS-1 are byte-writable and exported flat on reg_out.
module axi4lite_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
  input  logic                           axi_awvalid,
  output logic                           axi_awready,
  input  logic [DATA_WIDTH-1:0]          axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  input  logic                           axi_wvalid,
  output logic                           axi_wready,
  output logic [1:0]                     axi_bresp,
  output logic                           axi_bvalid,
  input  logic                           axi_bready,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int                    IDX_W       = $clog2(NUM_REGS);
  localparam int                    STRB_W      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_captured;
  logic                  w_captured;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_ok;
  logic                  rd_in_range;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Readies are forced low while reset is asserted, high right after release.
  assign axi_awready = axi_aresetn && !aw_captured && !axi_bvalid;
  assign axi_wready  = axi_aresetn && !w_captured && !axi_bvalid;
  assign axi_arready = axi_aresetn && !axi_rvalid;

  assign wr_idx      = aw_addr_q[2 +: IDX_W];
  assign wr_ok       = (aw_addr_q < ADDR_LIMIT) && (wr_idx != '0);
  assign commit      = aw_captured && w_captured;
  assign rd_idx      = axi_araddr[2 +: IDX_W];
  assign rd_in_range = axi_araddr < ADDR_LIMIT;
  assign rd_word     = (rd_idx == '0) ? ID_VALUE : regs[rd_idx];

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = (i == 0) ? ID_VALUE : regs[i];
    end
  end

  // Write path: AW and W captured independently; commit one cycle after both are held.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_captured  <= 1'b0;
      w_captured   <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      axi_bvalid   <= 1'b0;
      axi_bresp    <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr_pulse <= '0;
      if (axi_awvalid && axi_awready) begin
        aw_captured <= 1'b1;
        aw_addr_q   <= axi_awaddr;
      end
      if (axi_wvalid && axi_wready) begin
        w_captured <= 1'b1;
        w_data_q   <= axi_wdata;
        w_strb_q   <= axi_wstrb;
      end
      if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end
      // Flags can only be set while bvalid is low, so commit never collides with a B handshake.
      if (commit) begin
        aw_captured <= 1'b0;
        w_captured  <= 1'b0;
        axi_bvalid  <= 1'b1;
        if (wr_ok) begin
          axi_bresp            <= RESP_OKAY;
          reg_wr_pulse[wr_idx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) begin
              regs[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
        end else begin
          axi_bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read path samples the register file at the AR handshake, so a same-cycle commit is not seen.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= RESP_OKAY;
    end else if (axi_arvalid && axi_arready) begin
      axi_rvalid <= 1'b1;
      if (rd_in_range) begin
        axi_rdata <= rd_word;
        axi_rresp <= RESP_OKAY;
      end else begin
        axi_rdata <= '0;
        axi_rresp <= RESP_SLVERR;
      end
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank: scoreboard queues hold expected B and R
// responses, filled when a transaction is issued and drained as the DUT responds.
module tb_axi4lite_regbank;

  localparam int          DW = 32;
  localparam int          AW = 32;
  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA11E_0001;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              axi_aresetn;
  logic [AW-1:0]     axi_awaddr;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DW-1:0]     axi_wdata;
  logic [DW/8-1:0]   axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [AW-1:0]     axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DW-1:0]     axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     reg_wr_pulse;

  int                checks = 0;
  int                errors = 0;
  logic [1:0]        exp_b[$];
  rd_exp_t           exp_r[$];
  logic [31:0]       model [NR];
  int                pulse_cnt [NR];

  always #5 clk = ~clk;

  axi4lite_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .ID_VALUE(ID)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // Each strobe is one cycle wide, so sampling on the falling edge counts it exactly once.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (reg_wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int pulse_total();
    int t = 0;
    for (int i = 0; i < NR; i++) t += pulse_cnt[i];
    return t;
  endfunction

  function automatic rd_exp_t exp_word(input logic [31:0] addr);
    rd_exp_t e;
    logic [2:0] idx;
    idx = addr[4:2];
    if (addr >= 32'(NR * 4)) e = '{data: 32'h0, resp: 2'b10};
    else if (idx == 3'd0)    e = '{data: ID, resp: 2'b00};
    else                     e = '{data: model[idx], resp: 2'b00};
    return e;
  endfunction

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [2:0] idx;
    idx = addr[4:2];
    if (addr < 32'(NR * 4) && idx != 3'd0) begin
      exp_b.push_back(2'b00);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit do_aw, input bit do_w);
    bit aw_go;
    bit w_go;
    int n = 0;
    if (do_aw) begin axi_awaddr = addr; axi_awvalid = 1'b1; end
    if (do_w) begin axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1; end
    while ((axi_awvalid || axi_wvalid) && n < 20) begin
      aw_go = axi_awvalid && axi_awready;
      w_go  = axi_wvalid && axi_wready;
      @(posedge clk); #1; n++;
      if (aw_go) axi_awvalid = 1'b0;
      if (w_go)  axi_wvalid  = 1'b0;
    end
    checks++;
    if (axi_awvalid || axi_wvalid) begin
      errors++;
      $display("[TB] FAIL wr_handshake addr=%h: awvalid=%b wvalid=%b pending, required accepted in 20 cycles",
               addr, axi_awvalid, axi_wvalid);
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
    end
  endtask

  task automatic collect_b(input string name);
    int n = 0;
    logic [1:0] e;
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!axi_bvalid) begin
      errors++;
      $display("[TB] FAIL %s: bvalid=0 after 20 cycles, required 1", name);
    end else if (exp_b.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got bresp=%b with no expected response queued", name, axi_bresp);
    end else begin
      e = exp_b.pop_front();
      if (axi_bresp !== e) begin
        errors++;
        $display("[TB] FAIL %s: bresp=%b, required %b", name, axi_bresp, e);
      end
    end
    @(posedge clk); #1;
    axi_bready = 1'b0;
    checks++;
    if (axi_bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_clear: bvalid=%b after handshake, required 0", name, axi_bvalid);
    end
  endtask

  task automatic drive_ar(input logic [31:0] addr);
    bit done = 1'b0;
    bit go;
    int n = 0;
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    while (!done && n < 20) begin
      go = axi_arready;
      @(posedge clk); #1; n++;
      done = go;
    end
    axi_arvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL ar_handshake addr=%h: arready never seen, required accepted in 20 cycles", addr);
    end
  endtask

  task automatic collect_r(input string name);
    int n = 0;
    rd_exp_t e;
    axi_rready = 1'b1;
    while (!axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!axi_rvalid) begin
      errors++;
      $display("[TB] FAIL %s: rvalid=0 after 20 cycles, required 1", name);
    end else if (exp_r.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got rdata=%h with no expected response queued", name, axi_rdata);
    end else begin
      e = exp_r.pop_front();
      if (axi_rdata !== e.data || axi_rresp !== e.resp) begin
        errors++;
        $display("[TB] FAIL %s: rdata=%h rresp=%b, required rdata=%h rresp=%b",
                 name, axi_rdata, axi_rresp, e.data, e.resp);
      end
    end
    @(posedge clk); #1;
    axi_rready = 1'b0;
    checks++;
    if (axi_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_clear: rvalid=%b after handshake, required 0", name, axi_rvalid);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input string name);
    exp_r.push_back(exp_word(addr));
    drive_ar(addr);
    collect_r(name);
  endtask

  task automatic test_reset();
    axi_aresetn = 1'b0;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    axi_bready  = 1'b0; axi_rready = 1'b0;
    axi_awaddr  = '0; axi_wdata = '0; axi_wstrb = '0; axi_araddr = '0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_ready: aw/w/ar ready=%b, required 000", {axi_awready, axi_wready, axi_arready});
    end
    checks++;
    if (axi_bvalid !== 1'b0 || axi_rvalid !== 1'b0 || axi_rdata !== 32'h0 || reg_wr_pulse !== '0) begin
      errors++;
      $display("[TB] FAIL rst_outputs: bvalid=%b rvalid=%b rdata=%h pulse=%b, required 0 0 0 0",
               axi_bvalid, axi_rvalid, axi_rdata, reg_wr_pulse);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (reg_out[i*DW +: DW] !== ((i == 0) ? ID : 32'h0)) begin
        errors++;
        $display("[TB] FAIL rst_reg%0d: reg_out=%h, required %h", i, reg_out[i*DW +: DW], (i == 0) ? ID : 32'h0);
      end
    end
    axi_aresetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL rst_release_ready: aw/w/ar ready=%b, required 111", {axi_awready, axi_wready, axi_arready});
    end
  endtask

  task automatic test_write_read();
    int base1 = pulse_cnt[1];
    int tot   = pulse_total();
    push_write(32'h4, 32'hDEADBEEF, 4'hF);
    drive_write(32'h4, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    collect_b("wr_basic_bresp");
    checks++;
    if (pulse_cnt[1] - base1 != 1 || pulse_total() - tot != 1) begin
      errors++;
      $display("[TB] FAIL wr_basic_pulse: pulses idx1=%0d total=%0d, required 1 1", pulse_cnt[1] - base1, pulse_total() - tot);
    end
    checks++;
    if (reg_out[1*DW +: DW] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL wr_basic_regout: reg_out[1]=%h, required deadbeef", reg_out[1*DW +: DW]);
    end
    exp_r.push_back(exp_word(32'h4));
    drive_ar(32'h4);
    checks++;
    if (axi_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_latency: rvalid=%b one cycle after AR handshake, required 1", axi_rvalid);
    end
    collect_r("rd_basic");
  endtask

  task automatic test_w_before_aw();
    int base2 = pulse_cnt[2];
    push_write(32'h8, 32'h12345678, 4'h3);
    drive_write(32'h8, 32'h12345678, 4'h3, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (axi_bvalid !== 1'b0 || axi_wready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL w_first_wait%0d: bvalid=%b wready=%b, required 0 0", c, axi_bvalid, axi_wready);
      end
      @(posedge clk); #1;
    end
    drive_write(32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
    collect_b("w_first_bresp");
    checks++;
    if (pulse_cnt[2] - base2 != 1) begin
      errors++;
      $display("[TB] FAIL w_first_pulse: pulses idx2=%0d, required 1", pulse_cnt[2] - base2);
    end
    do_read(32'h8, "w_first_read");
  endtask

  task automatic test_slverr();
    int tot = pulse_total();
    push_write(32'h0, 32'hFFFFFFFF, 4'hF);
    drive_write(32'h0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    collect_b("wr_id_bresp");
    push_write(32'h24, 32'h0BAD0BAD, 4'hF);
    drive_write(32'h24, 32'h0BAD0BAD, 4'hF, 1'b1, 1'b1);
    collect_b("wr_oor_bresp");
    checks++;
    if (pulse_total() - tot != 0 || reg_out[0 +: DW] !== ID) begin
      errors++;
      $display("[TB] FAIL slverr_effect: pulses=%0d reg_out[0]=%h, required 0 %h", pulse_total() - tot, reg_out[0 +: DW], ID);
    end
    do_read(32'h0, "rd_id");
    do_read(32'h20, "rd_oor");
  endtask

  task automatic test_b_backpressure();
    int n = 0;
    int base5;
    logic [1:0] e;
    push_write(32'h10, 32'hA5A50F0F, 4'hF);
    drive_write(32'h10, 32'hA5A50F0F, 4'hF, 1'b1, 1'b1);
    while (!axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!axi_bvalid) begin
      errors++;
      $display("[TB] FAIL bp_bvalid: bvalid=0 after 20 cycles, required 1");
    end
    e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
    axi_awaddr  = 32'h14;
    axi_awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (axi_bvalid !== 1'b1 || axi_bresp !== e || axi_awready !== 1'b0 || axi_wready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: bvalid=%b bresp=%b awready=%b wready=%b, required 1 %b 0 0",
                 c, axi_bvalid, axi_bresp, axi_awready, axi_wready, e);
      end
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    checks++;
    if (axi_bvalid !== 1'b0 || axi_awready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: bvalid=%b awready=%b, required 0 1", axi_bvalid, axi_awready);
    end
    base5 = pulse_cnt[5];
    push_write(32'h14, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    checks++;
    if (axi_awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_new_aw: awready=%b after release, required 0 (AW captured)", axi_awready);
    end
    drive_write(32'h14, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    collect_b("bp_second_bresp");
    checks++;
    if (pulse_cnt[5] - base5 != 1 || reg_out[5*DW +: DW] !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL bp_second_commit: pulses=%0d reg_out[5]=%h, required 1 cafef00d",
               pulse_cnt[5] - base5, reg_out[5*DW +: DW]);
    end
  endtask

  task automatic test_read_during_commit();
    push_write(32'hC, 32'h1, 4'hF);
    drive_write(32'hC, 32'h1, 4'hF, 1'b1, 1'b1);
    collect_b("rdc_init_bresp");
    exp_r.push_back(exp_word(32'hC));
    push_write(32'hC, 32'h2, 4'hF);
    axi_awaddr = 32'hC; axi_wdata = 32'h2; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    checks++;
    if (axi_awready !== 1'b1 || axi_wready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rdc_ready: awready=%b wready=%b, required 1 1", axi_awready, axi_wready);
    end
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_araddr  = 32'hC; axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    checks++;
    if (axi_bvalid !== 1'b1 || axi_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rdc_same_cycle: bvalid=%b rvalid=%b, required 1 1", axi_bvalid, axi_rvalid);
    end
    collect_r("rdc_pre_write");
    collect_b("rdc_bresp");
    do_read(32'hC, "rdc_post_write");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    for (int k = 0; k < 6; k++) begin
      addr = 32'($urandom_range(4, 7) * 4 + $urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      push_write(addr, data, strb);
      drive_write(addr, data, strb, 1'b1, 1'b1);
      collect_b("b2b_bresp");
      do_read(addr, "b2b_read");
    end
    for (int i = 0; i < NR; i++) begin
      do_read(32'(i * 4), "b2b_sweep");
    end
  endtask

  task automatic test_reset_mid_txn();
    int tot;
    drive_write(32'h18, 32'h0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (axi_awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_aw_captured: awready=%b, required 0", axi_awready);
    end
    axi_aresetn = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    tot = pulse_total();
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b000 || axi_bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_in_reset: ready=%b bvalid=%b, required 000 0",
               {axi_awready, axi_wready, axi_arready}, axi_bvalid);
    end
    axi_aresetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL mid_release_ready: ready=%b, required 111", {axi_awready, axi_wready, axi_arready});
    end
    drive_write(32'h18, 32'h5555AAAA, 4'hF, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (axi_bvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_no_bvalid%0d: bvalid=%b, required 0", c, axi_bvalid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulse_total() != tot || reg_out[6*DW +: DW] !== 32'h0 || reg_out[1*DW +: DW] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_no_commit: pulses=%0d reg6=%h reg1=%h, required 0 0 0",
               pulse_total() - tot, reg_out[6*DW +: DW], reg_out[1*DW +: DW]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_slverr();
    test_b_backpressure();
    test_read_during_commit();
    test_back_to_back();
    test_reset_mid_txn();
    checks++;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d B and %0d R responses outstanding, required 0 0",
               exp_b.size(), exp_r.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_regbank.md
AXI4LITE_REGBANK -- requirements
Module: axi4lite_regbank

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI4-Lite address width.
- REQ-003 SHALL have parameter NUM_REGS, default 8: register count; power of two, 2..256.
- REQ-004 SHALL have parameter ID_VALUE, default 32'hA11E_0001: constant read from register 0.
- REQ-005 SHALL have the following clock, reset and AXI slave ports:
  - axi_aclk, input, 1: the single clock.
  - axi_aresetn, input, 1: reset, synchronous and active-low.
  - axi_awaddr, input, ADDR_WIDTH: write address.
  - axi_awvalid, input, 1 / axi_awready, output, 1: AW handshake.
  - axi_wdata, input, DATA_WIDTH: write data.
  - axi_wstrb, input, DATA_WIDTH/8: byte enables.
  - axi_wvalid, input, 1 / axi_wready, output, 1: W handshake.
  - axi_bresp, output, 2 / axi_bvalid, output, 1 / axi_bready, input, 1: B channel.
  - axi_araddr, input, ADDR_WIDTH / axi_arvalid, input, 1 / axi_arready, output, 1: AR channel.
  - axi_rdata, output, DATA_WIDTH / axi_rresp, output, 2 / axi_rvalid, output, 1 / axi_rready, input, 1: R channel.
- REQ-006 SHALL have output reg_out, NUM_REGS*DATA_WIDTH: flat register contents; slice i = register i; slice 0 = ID_VALUE.
- REQ-007 SHALL have output reg_wr_pulse, NUM_REGS: one-cycle strobe in the cycle register i is updated.

Function
- REQ-008 SHALL decode word index as addr[2 +: log2(NUM_REGS)]; addr[1:0] ignored.
- REQ-009 SHALL treat any address with addr >= NUM_REGS*4 as out of range.
- REQ-010 SHALL accept AW and W independently, in either order or the same cycle.
  - Each channel gets a capture flag.
  - awready = !aw_captured && !axi_bvalid; wready = !w_captured && !axi_bvalid.
- REQ-011 SHALL commit the write in the cycle after both flags are set.
  - Per-byte update using wstrb; wstrb=0 is legal and changes nothing.
  - Set axi_bvalid, clear both flags, pulse reg_wr_pulse[idx] in the same cycle.
- REQ-012 SHALL return bresp 2'b00 (OKAY) for an in-range write to index 1..NUM_REGS-1.
- REQ-013 SHALL return bresp 2'b10 (SLVERR) for a write to index 0 or out of range; no register change, no pulse.
- REQ-014 SHALL hold axi_bvalid and axi_bresp stable until axi_bready is high; bvalid clears the cycle after the B handshake.
- REQ-015 SHALL allow at most one outstanding write; no AW/W accepted while bvalid=1.
- REQ-016 SHALL drive axi_arready = !axi_rvalid.
- REQ-017 SHALL, on AR handshake, register rdata and rresp and assert axi_rvalid the next cycle (1-cycle latency).
- REQ-018 SHALL return rresp 2'b00 with register contents for in-range reads.
  - Index 0 returns ID_VALUE.
  - Out-of-range reads return rdata 0 and rresp 2'b10.
- REQ-019 SHALL hold axi_rdata, axi_rresp and axi_rvalid stable until axi_rready is high; clear rvalid the cycle after the R handshake.
- REQ-020 SHALL sample read data in the AR handshake cycle.
  - A write committing in that same cycle to the same index returns the pre-write value.
- REQ-021 SHALL operate the read and write paths fully concurrently with no mutual stalls.

Reset
- REQ-022 SHALL, while axi_aresetn=0 at a clock edge, reset the following:
  - Registers 1..NUM_REGS-1 to 0.
  - Capture flags to 0.
  - axi_bvalid=0, axi_rvalid=0, axi_bresp=0, axi_rresp=0, axi_rdata=0, reg_wr_pulse=0.
- REQ-023 SHALL drive awready, wready and arready to 0 during reset and to 1 in the first cycle after reset release.
- REQ-024 SHALL, on reset mid-transaction, discard captured AW/W and pending B/R responses without committing the write.

Verification
- REQ-025 Write 0x4 data 0xDEADBEEF wstrb 0xF, then read 0x4 -> bresp 00, reg_wr_pulse[1] one cycle, rdata 0xDEADBEEF rresp 00.
- REQ-026 W issued 3 cycles before AW (addr 0x8, data 0x12345678, wstrb 0x3) on a zeroed register -> single commit; read 0x8 returns 0x00005678.
- REQ-027 Write 0x0 data 0xFFFFFFFF -> bresp 10, no pulse; read 0x0 returns ID_VALUE rresp 00; read 0x20 (NUM_REGS=8) returns 0, rresp 10.
- REQ-028 bready held low 5 cycles after bvalid -> bvalid/bresp stable, awready=wready=0 throughout; a new AW is accepted the cycle after bvalid clears.
- REQ-029 AR to 0xC in the same cycle that a write to 0xC (old 0x1, new 0x2) commits -> rdata 0x1; a following read returns 0x2.
- REQ-030 AW captured, then axi_aresetn=0 for 1 cycle before W arrives -> no commit, no bvalid, register unchanged, all ready signals 1 after release.
